seq_multiply: RTL

- Sequential shift-add integer multiplier producing a 2*WIDTH-bit product from two WIDTH-bit operands, one partial product per clock.
- It is the inverse of the team's single-cycle-per-bit non-restoring divider and uses the same start/done handshake.
- Its product layout matches the divider's 2*WIDTH numerator input, so multiply and divide units in the arithmetic datapath are interchangeable behind one sequencer.
- It supports unsigned and two's-complement signed operation, and flags products that do not fit in WIDTH bits.

---
 rtl/seq_multiply.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_multiply.sv
// Sequential shift-add multiplier: one partial product per clock, 2*WIDTH-bit result.
// Unsigned or two's-complement operands, start/done handshake shared with the divider.
module seq_multiply #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow,
    output logic               done
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoop,
        StFinish
    } phase_e;

    phase_e             phase_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mreg_q;
    logic               signed_q;
    logic [WIDTH:0]     acc_q;
    logic [CntW-1:0]    count_q;
    logic [2*WIDTH-1:0] product_q;
    logic               overflow_q;
    logic               done_q;

    logic [WIDTH:0]     pp;
    logic [WIDTH:0]     term;
    logic               subtract;
    logic [WIDTH+1:0]   sum_wide;
    logic [WIDTH:0]     sum;
    logic               acc_msb;
    logic [2*WIDTH-1:0] result;
    logic               result_ovf;

    always_comb begin
        pp       = signed_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
        term     = mreg_q[0] ? pp : '0;
        // Multiplier MSB has weight -2^(WIDTH-1) for signed operands.
        subtract = signed_q && (count_q == '0);
        sum_wide = subtract ? ({1'b0, acc_q} - {1'b0, term})
                            : ({1'b0, acc_q} + {1'b0, term});
        sum      = sum_wide[WIDTH:0];
        acc_msb  = signed_q ? sum[WIDTH] : sum_wide[WIDTH+1];
    end

    always_comb begin
        result = {acc_q[WIDTH-1:0], mreg_q};
        if (signed_q) begin
            result_ovf = (result[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){result[2*WIDTH-1]}});
        end else begin
            result_ovf = |result[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q    <= StIdle;
            mcand_q    <= '0;
            mreg_q     <= '0;
            signed_q   <= 1'b0;
            acc_q      <= '0;
            count_q    <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            unique case (phase_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= multiplicand;
                        mreg_q   <= multiplier;
                        signed_q <= signed_op;
                        acc_q    <= '0;
                        count_q  <= CntW'(WIDTH - 1);
                        done_q   <= 1'b0;
                        phase_q  <= StLoop;
                    end
                end
                StLoop: begin
                    acc_q   <= {acc_msb, sum[WIDTH:1]};
                    mreg_q  <= {sum[0], mreg_q[WIDTH-1:1]};
                    count_q <= count_q - CntW'(1);
                    if (count_q == '0) begin
                        phase_q <= StFinish;
                    end
                end
                StFinish: begin
                    product_q  <= result;
                    overflow_q <= result_ovf;
                    done_q     <= 1'b1;
                    phase_q    <= StIdle;
                end
                default: begin
                    phase_q <= StIdle;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign product  = product_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule
